// File: rtl/stage_execute_md.sv
// stage_execute_md: execute stage with ALU, branch target and an iterative unsigned multu/divu unit
// that owns the HI/LO registers and stalls upstream only for instructions that depend on it.
module stage_execute_md #(
  parameter int WIDTH = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               flush,
  input  logic               alusrc,
  input  logic               regdst,
  input  logic [2:0]         alucontrol,
  input  logic [1:0]         mdop,
  input  logic [1:0]         resultsel,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic [REGBITS-1:0] rt,
  input  logic [REGBITS-1:0] rd,
  input  logic [WIDTH-1:0]   signimm,
  input  logic [WIDTH-1:0]   pcplus4,
  output logic               stall,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   aluresult,
  output logic               zero,
  output logic               overflow,
  output logic [REGBITS-1:0] writereg,
  output logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   pcbranch,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] srcb, sum, dif, alu, m;
  logic [2*WIDTH-1:0] p, p_n;
  logic [WIDTH:0] madd, rsh, rsub;
  logic [CW-1:0] cnt;
  logic ovf, busy, last, accept, md_op;
  assign busy = state != IDLE;
  assign last = busy && cnt == CW'(1);
  assign md_op = mdop == 2'b01 || mdop == 2'b10;
  assign stall = busy && in_valid && (mdop != 2'b00 || resultsel == 2'b01 || resultsel == 2'b10);
  assign accept = in_valid && !stall && !flush;
  always_comb begin
    srcb = alusrc ? signimm : reg2;
    sum = reg1 + srcb;
    dif = reg1 - srcb;
    alu = alucontrol == 3'b010 ? sum :
          alucontrol == 3'b110 ? dif :
          alucontrol == 3'b000 ? reg1 & srcb :
          alucontrol == 3'b001 ? reg1 | srcb :
          alucontrol == 3'b111 ? {{(WIDTH-1){1'b0}}, $signed(reg1) < $signed(srcb)} : '0;
    ovf = alucontrol == 3'b010 ? reg1[WIDTH-1] == srcb[WIDTH-1] && sum[WIDTH-1] != reg1[WIDTH-1] :
          alucontrol == 3'b110 ? reg1[WIDTH-1] != srcb[WIDTH-1] && dif[WIDTH-1] != reg1[WIDTH-1] : 1'b0;
  end
  // p holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV,
  // so both operations finish with {hi,lo} equal to p.
  always_comb begin
    madd = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    rsh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    rsub = rsh - {1'b0, m};
    p_n = state == MUL ? {madd, p[WIDTH-1:1]} :
          rsub[WIDTH] ? {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {rsub[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end
  always_comb begin
    state_n = flush ? IDLE :
              !busy ? (accept && mdop == 2'b01 ? MUL : accept && mdop == 2'b10 ? DIV : IDLE) :
              last ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      m <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (!busy) begin
      if (accept && md_op) begin
        p <= {{WIDTH{1'b0}}, mdop[0] ? reg2 : reg1};
        m <= mdop[0] ? reg1 : reg2;
        cnt <= CW'(WIDTH);
      end
    end else begin
      p <= p_n;
      cnt <= cnt - CW'(1);
      if (last) {hi, lo} <= p_n;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid <= 1'b0;
      aluresult <= '0;
      zero <= 1'b0;
      overflow <= 1'b0;
      writereg <= '0;
      writedata <= '0;
      pcbranch <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        aluresult <= resultsel == 2'b01 ? hi : resultsel == 2'b10 ? lo : alu;
        zero <= alu == '0;
        overflow <= ovf;
        writereg <= md_op ? '0 : regdst ? rd : rt;
        writedata <= reg2;
        pcbranch <= pcplus4 + (signimm << 2);
      end
    end
endmodule
